// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache controller.
// The width helpers take the top-level parameters so every file derives identical field splits.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Byte offset within a block: word-select bits plus the ignored byte bit.
  function automatic int calc_off_w(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets, input int words);
    return addr_w - calc_off_w(words) - calc_idx_w(sets);
  endfunction

  // One extra bit so issue/return counters can reach WORDS.
  function automatic int calc_cnt_w(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int calc_ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag, valid and data arrays with a synchronous write port
// and combinational lookup/compare.
module cache_way #(
  parameter int TAG_W  = 9,
  parameter int IDX_W  = 3,
  parameter int WL     = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  lk_idx,
  input  logic [TAG_W-1:0]  lk_tag,
  input  logic [WL-1:0]     lk_word,
  output logic              hit,
  output logic              lk_valid,
  output logic [DATA_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WL-1:0]     wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              v_clr,
  input  logic              v_set,
  input  logic [TAG_W-1:0]  v_tag
);

  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = 1 << WL;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS*WORDS];

  // A whole-cache clear overrides any per-line valid update in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid <= '0;
    end else begin
      if (v_clr) valid[lk_idx] <= 1'b0;
      if (v_set) valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (v_set) tag_mem[wr_idx] <= v_tag;
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
  end

  assign lk_valid = valid[lk_idx];
  assign hit      = lk_valid && (tag_mem[lk_idx] == lk_tag);
  assign rd_word  = data_mem[{lk_idx, lk_word}];

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate set-associative cache controller with
// blocking block fill from a pipelined main memory and whole-cache invalidate.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WAYS    = 2,
  parameter int SETS    = 8,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  input  logic              inv,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = calc_off_w(WORDS);
  localparam int IDX_W = calc_idx_w(SETS);
  localparam int TAG_W = calc_tag_w(ADDR_W, SETS, WORDS);
  localparam int CNT_W = calc_cnt_w(WORDS);
  localparam int WL    = CNT_W - 1;
  localparam int PTR_W = calc_ptr_w(WAYS);
  // Memory latency only shapes the external timing; the controller counts returns instead.
  localparam bit unused_cfg = (MEM_LAT >= 1);

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic [TAG_W-1:0]  blk_tag;
  logic [IDX_W-1:0]  blk_idx;
  logic [PTR_W-1:0]  victim_q;
  logic              repl_q;
  logic [PTR_W-1:0]  ptr [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WL-1:0]     word;
  logic              unused_addr_bit;

  logic [WAYS-1:0]   way_hit, way_valid, way_dwe, way_vclr, way_vset;
  logic [DATA_W-1:0] way_rd [WAYS];
  logic              hit, found, all_valid;
  logic [PTR_W-1:0]  victim, next_ptr;
  logic              in_fill, load_miss, store_req, fill_ret, last_ret, clr_all;
  logic [IDX_W-1:0]  line_idx;
  logic [WL-1:0]     line_word;
  logic [DATA_W-1:0] line_data;

  assign idx             = addr[OFF_W +: IDX_W];
  assign tag             = addr[ADDR_W-1 -: TAG_W];
  assign word            = addr[1 +: WL];
  assign unused_addr_bit = addr[0];

  assign in_fill   = (state == FILL);
  assign load_miss = !in_fill && req && !wr && !hit;
  assign store_req = !in_fill && req && wr;
  assign fill_ret  = in_fill && mem_rvalid;
  assign last_ret  = fill_ret && (ret_cnt == CNT_W'(WORDS - 1));
  assign clr_all   = rst || (!in_fill && inv);
  assign all_valid = &way_valid;
  assign next_ptr  = (WAYS == 1) ? '0 : ptr[blk_idx] + 1'b1;

  assign line_idx  = in_fill ? blk_idx : idx;
  assign line_word = in_fill ? ret_cnt[WL-1:0] : word;
  assign line_data = in_fill ? mem_rdata : wdata;

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit   = 1'b1;
        rdata = way_rd[w];
      end
    end
  end

  // Lowest-index invalid way wins; the round-robin pointer only matters when the set is full.
  always_comb begin
    victim = ptr[idx];
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        victim = PTR_W'(w);
        found  = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_dwe[g]  = (store_req && way_hit[g]) || (fill_ret && victim_q == PTR_W'(g));
    assign way_vclr[g] = load_miss && (victim == PTR_W'(g));
    assign way_vset[g] = last_ret && (victim_q == PTR_W'(g));

    cache_way #(
      .TAG_W (TAG_W),
      .IDX_W (IDX_W),
      .WL    (WL),
      .DATA_W(DATA_W)
    ) u_way (
      .clk     (clk),
      .clr_all (clr_all),
      .lk_idx  (idx),
      .lk_tag  (tag),
      .lk_word (word),
      .hit     (way_hit[g]),
      .lk_valid(way_valid[g]),
      .rd_word (way_rd[g]),
      .wr_en   (way_dwe[g]),
      .wr_idx  (line_idx),
      .wr_word (line_word),
      .wr_data (line_data),
      .v_clr   (way_vclr[g]),
      .v_set   (way_vset[g]),
      .v_tag   (blk_tag)
    );
  end

  assign stall     = in_fill || load_miss;
  assign mem_rd    = in_fill && (issue_cnt != CNT_W'(WORDS));
  assign mem_we    = store_req;
  assign mem_addr  = in_fill ? {blk_tag, blk_idx, issue_cnt[WL-1:0], 1'b0} : addr;
  assign mem_wdata = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      blk_tag   <= '0;
      blk_idx   <= '0;
      victim_q  <= '0;
      repl_q    <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv) begin
            for (int unsigned s = 0; s < SETS; s++) ptr[s] <= '0;
          end
          if (load_miss) begin
            blk_tag   <= tag;
            blk_idx   <= idx;
            victim_q  <= victim;
            repl_q    <= all_valid;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (mem_rd) issue_cnt <= issue_cnt + 1'b1;
          if (mem_rvalid) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (last_ret) begin
              state <= IDLE;
              if (repl_q) ptr[blk_idx] <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: default 2-way instance plus 1-way and 4-way
// instances (WORDS=4, MEM_LAT=1); each memory model returns data = address.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, wr, inv;
  logic [15:0] addr, wdata;
  int          sel;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rd_q [$];

  always #5 clk = ~clk;

  logic req0, req1, req2;
  assign req0 = req && (sel == 0);
  assign req1 = req && (sel == 1);
  assign req2 = req && (sel == 2);

  // Default instance and its 4-cycle memory
  logic [15:0] m_rdata, m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic        m_stall, m_mem_rd, m_mem_we, m_rvalid;
  logic [3:0]  m_pv = '0;
  logic [15:0] m_pa [4];

  cache_ctrl u_dut (
    .clk(clk), .rst(rst), .req(req0), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(m_rdata), .stall(m_stall), .inv(inv), .mem_rd(m_mem_rd), .mem_we(m_mem_we),
    .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_rvalid(m_rvalid), .mem_rdata(m_mem_rdata)
  );

  always @(posedge clk) begin
    m_pv    <= {m_pv[2:0], m_mem_rd};
    m_pa[0] <= m_mem_addr;
    for (int i = 1; i < 4; i++) m_pa[i] <= m_pa[i-1];
  end
  assign m_rvalid    = m_pv[3];
  assign m_mem_rdata = m_pa[3];

  // 1-way and 4-way instances with 1-cycle memory
  logic [15:0] s1_rdata, s1_mem_addr, s1_mem_wdata, s1_pa;
  logic        s1_stall, s1_mem_rd, s1_mem_we;
  logic        s1_pv = 1'b0;
  logic [15:0] s2_rdata, s2_mem_addr, s2_mem_wdata, s2_pa;
  logic        s2_stall, s2_mem_rd, s2_mem_we;
  logic        s2_pv = 1'b0;

  cache_ctrl #(.WAYS(1), .WORDS(4), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(s1_rdata), .stall(s1_stall), .inv(inv), .mem_rd(s1_mem_rd), .mem_we(s1_mem_we),
    .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata), .mem_rvalid(s1_pv), .mem_rdata(s1_pa)
  );

  cache_ctrl #(.WAYS(4), .WORDS(4), .MEM_LAT(1)) u_dut4 (
    .clk(clk), .rst(rst), .req(req2), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(s2_rdata), .stall(s2_stall), .inv(inv), .mem_rd(s2_mem_rd), .mem_we(s2_mem_we),
    .mem_addr(s2_mem_addr), .mem_wdata(s2_mem_wdata), .mem_rvalid(s2_pv), .mem_rdata(s2_pa)
  );

  always @(posedge clk) begin
    s1_pv <= s1_mem_rd;
    s1_pa <= s1_mem_addr;
    s2_pv <= s2_mem_rd;
    s2_pa <= s2_mem_addr;
  end

  logic        o_stall, o_mem_rd;
  logic [15:0] o_rdata, o_mem_addr;
  assign o_stall    = (sel == 0) ? m_stall    : (sel == 1) ? s1_stall    : s2_stall;
  assign o_mem_rd   = (sel == 0) ? m_mem_rd   : (sel == 1) ? s1_mem_rd   : s2_mem_rd;
  assign o_rdata    = (sel == 0) ? m_rdata    : (sel == 1) ? s1_rdata    : s2_rdata;
  assign o_mem_addr = (sel == 0) ? m_mem_addr : (sel == 1) ? s1_mem_addr : s2_mem_addr;

  // Starts at a falling edge; returns stall-cycle count, data and issued read addresses.
  task automatic do_load(input logic [15:0] a, output int n, output logic [15:0] d);
    req = 1'b1; wr = 1'b0; addr = a; n = 0;
    rd_q.delete();
    #1;
    while (o_stall === 1'b1 && n < 100) begin
      if (o_mem_rd === 1'b1) rd_q.push_back(o_mem_addr);
      n++;
      @(negedge clk); #1;
    end
    d = o_rdata;
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    checks++; if (m_mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", m_mem_rd); end
    checks++; if (m_mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", m_mem_we); end
    checks++; if (o_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", o_rdata); end
    @(negedge clk);
  endtask

  task automatic test_cold_load;
    int n; logic [15:0] d;
    do_load(16'h0046, n, d);
    checks++; if (n != 13) begin errors++; $display("FAIL cold_penalty: got %0d want 13", n); end
    checks++; if (d !== 16'h0046) begin errors++; $display("FAIL cold_data: got %h want 0046", d); end
    checks++; if (rd_q.size() != 8) begin errors++; $display("FAIL cold_rd_count: got %0d want 8", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 8; i++) begin
      checks++;
      if (rd_q[i] !== 16'h0040 + 16'(2*i)) begin
        errors++; $display("FAIL cold_rd_addr[%0d]: got %h want %h", i, rd_q[i], 16'h0040 + 16'(2*i));
      end
    end
    do_load(16'h0040, n, d);
    checks++; if (n != 0) begin errors++; $display("FAIL reload_hit_stall: got %0d want 0", n); end
    checks++; if (d !== 16'h0040) begin errors++; $display("FAIL reload_hit_data: got %h want 0040", d); end
  endtask

  task automatic test_store;
    int n; logic [15:0] d;
    req = 1'b1; wr = 1'b1; addr = 16'h0042; wdata = 16'hBEEF;
    #1;
    checks++; if (m_mem_we !== 1'b1) begin errors++; $display("FAIL st_hit_we: got %b want 1", m_mem_we); end
    checks++; if (m_mem_addr !== 16'h0042) begin errors++; $display("FAIL st_hit_addr: got %h want 0042", m_mem_addr); end
    checks++; if (m_mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL st_hit_wdata: got %h want beef", m_mem_wdata); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL st_hit_stall: got %b want 0", o_stall); end
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    do_load(16'h0042, n, d);
    checks++; if (n != 0 || d !== 16'hBEEF) begin errors++; $display("FAIL st_hit_readback: got %0d/%h want 0/beef", n, d); end
    do_load(16'h0044, n, d);
    checks++; if (n != 0 || d !== 16'h0044) begin errors++; $display("FAIL st_neighbor: got %0d/%h want 0/0044", n, d); end
    req = 1'b1; wr = 1'b1; addr = 16'h1000; wdata = 16'h1234;
    #1;
    checks++; if (m_mem_we !== 1'b1 || m_mem_addr !== 16'h1000) begin
      errors++; $display("FAIL st_miss_we: got %b/%h want 1/1000", m_mem_we, m_mem_addr);
    end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL st_miss_stall: got %b want 0", o_stall); end
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0 || o_mem_rd !== 1'b0) begin
      errors++; $display("FAIL st_miss_nofill: got stall %b rd %b want 0/0", o_stall, o_mem_rd);
    end
    @(negedge clk);
    do_load(16'h1000, n, d);
    checks++; if (n != 13 || d !== 16'h1000) begin errors++; $display("FAIL st_miss_load: got %0d/%h want 13/1000", n, d); end
  endtask

  task automatic test_conflict;
    int n; logic [15:0] d;
    do_load(16'h0440, n, d);
    checks++; if (n != 13) begin errors++; $display("FAIL conf_fill2: got %0d want 13", n); end
    do_load(16'h0840, n, d);
    checks++; if (n != 13 || d !== 16'h0840) begin errors++; $display("FAIL conf_fill3: got %0d/%h want 13/0840", n, d); end
    do_load(16'h0440, n, d);
    checks++; if (n != 0 || d !== 16'h0440) begin errors++; $display("FAIL conf_way1_kept: got %0d/%h want 0/0440", n, d); end
    do_load(16'h0840, n, d);
    checks++; if (n != 0) begin errors++; $display("FAIL conf_new_hit: got %0d want 0", n); end
    do_load(16'h0040, n, d);
    checks++; if (n != 13 || d !== 16'h0040) begin errors++; $display("FAIL conf_way0_evicted: got %0d/%h want 13/0040", n, d); end
  endtask

  task automatic test_invalidate;
    int n; logic [15:0] d;
    inv = 1'b1; req = 1'b1; wr = 1'b0; addr = 16'h0040;
    #1;
    checks++; if (o_stall !== 1'b0 || o_rdata !== 16'h0040) begin
      errors++; $display("FAIL inv_same_cycle_hit: got %b/%h want 0/0040", o_stall, o_rdata);
    end
    @(negedge clk);
    inv = 1'b0; req = 1'b0;
    do_load(16'h0040, n, d);
    checks++; if (n != 13) begin errors++; $display("FAIL inv_miss_0040: got %0d want 13", n); end
    do_load(16'h0840, n, d);
    checks++; if (n != 13) begin errors++; $display("FAIL inv_miss_0840: got %0d want 13", n); end
    req = 1'b1; addr = 16'h1040; n = 0;
    #1;
    while (o_stall === 1'b1 && n < 100) begin
      n++;
      inv = (n >= 2 && n <= 4);
      @(negedge clk); #1;
    end
    inv = 1'b0;
    checks++; if (n != 13 || o_rdata !== 16'h1040) begin
      errors++; $display("FAIL inv_in_fill: got %0d/%h want 13/1040", n, o_rdata);
    end
    req = 1'b0;
    @(negedge clk);
    do_load(16'h0840, n, d);
    checks++; if (n != 0 || d !== 16'h0840) begin errors++; $display("FAIL inv_in_fill_kept: got %0d/%h want 0/0840", n, d); end
  endtask

  task automatic test_reset_mid_fill;
    int n; logic [15:0] d; int late; bit bad;
    req = 1'b1; wr = 1'b0; addr = 16'h0060;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rmf_miss: got %b want 1", o_stall); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0 || o_mem_rd !== 1'b0) begin
      errors++; $display("FAIL rmf_idle: got stall %b rd %b want 0/0", o_stall, o_mem_rd);
    end
    late = 0; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_rvalid === 1'b1) late++;
      if (o_stall !== 1'b0 || o_mem_rd !== 1'b0) bad = 1'b1;
      @(negedge clk); #1;
    end
    checks++; if (late == 0) begin errors++; $display("FAIL rmf_late_seen: got 0 late returns want >0"); end
    checks++; if (bad) begin errors++; $display("FAIL rmf_late_ignored: got activity want none"); end
    @(negedge clk);
    do_load(16'h0060, n, d);
    checks++; if (n != 13 || d !== 16'h0060) begin errors++; $display("FAIL rmf_reload: got %0d/%h want 13/0060", n, d); end
    do_load(16'h0840, n, d);
    checks++; if (n != 13) begin errors++; $display("FAIL rmf_all_invalid: got %0d want 13", n); end
  endtask

  task automatic test_sweep_1way;
    int n; logic [15:0] d;
    sel = 1;
    do_load(16'h0046, n, d);
    checks++; if (n != 6 || d !== 16'h0046) begin errors++; $display("FAIL w1_cold: got %0d/%h want 6/0046", n, d); end
    checks++; if (rd_q.size() != 4 || rd_q[0] !== 16'h0040 || rd_q[rd_q.size()-1] !== 16'h0046) begin
      errors++; $display("FAIL w1_rd_addrs: got %0d reads want 4 from 0040 to 0046", rd_q.size());
    end
    do_load(16'h0040, n, d);
    checks++; if (n != 0 || d !== 16'h0040) begin errors++; $display("FAIL w1_hit: got %0d/%h want 0/0040", n, d); end
    do_load(16'h0086, n, d);
    checks++; if (n != 6 || d !== 16'h0086) begin errors++; $display("FAIL w1_conflict: got %0d/%h want 6/0086", n, d); end
    do_load(16'h0046, n, d);
    checks++; if (n != 6) begin errors++; $display("FAIL w1_evicted: got %0d want 6", n); end
  endtask

  task automatic test_sweep_4way;
    int n; logic [15:0] d;
    logic [15:0] blk [4];
    blk[0] = 16'h0040; blk[1] = 16'h0080; blk[2] = 16'h00C0; blk[3] = 16'h0100;
    sel = 2;
    for (int i = 0; i < 4; i++) begin
      do_load(blk[i], n, d);
      checks++; if (n != 6) begin errors++; $display("FAIL w4_fill[%0d]: got %0d want 6", i, n); end
    end
    for (int i = 0; i < 4; i++) begin
      do_load(blk[i], n, d);
      checks++; if (n != 0 || d !== blk[i]) begin errors++; $display("FAIL w4_hit[%0d]: got %0d/%h want 0/%h", i, n, d, blk[i]); end
    end
    do_load(16'h0140, n, d);
    checks++; if (n != 6 || d !== 16'h0140) begin errors++; $display("FAIL w4_fifth: got %0d/%h want 6/0140", n, d); end
    for (int i = 1; i < 4; i++) begin
      do_load(blk[i], n, d);
      checks++; if (n != 0) begin errors++; $display("FAIL w4_kept[%0d]: got %0d want 0", i, n); end
    end
    do_load(16'h0040, n, d);
    checks++; if (n != 6) begin errors++; $display("FAIL w4_way0_evicted: got %0d want 6", n); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 0; rst = 1'b1; req = 1'b0; wr = 1'b0; inv = 1'b0;
    addr = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_cold_load();
    test_store();
    test_conflict();
    test_invalidate();
    test_reset_mid_fill();
    test_sweep_1way();
    test_sweep_4way();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
